// File: rtl/fpga_status_led_ctrl.sv
// fpga_status_led_ctrl: board status LEDs for an FPGA-hosted SoC.
// Provides a heartbeat, an out-of-reset indicator and a sticky capture of the
// SoC exit code, which is shown as a pass LED or a fail LED.
// Optional macro STATUS_LED_BLINK_CODE_EN: when defined, the fail LED blinks
// the low nibble of the exit code (0 -> 16 pulses) in bursts separated by a
// gap. When undefined, the fail LED toggles on every blink tick.
module fpga_status_led_ctrl #(
    parameter int unsigned CLK_LED_COUNT_LENGTH = 27,
    parameter int unsigned BLINK_PRESCALE_W     = 24,
    parameter int unsigned EXIT_W               = 32,
    parameter int unsigned GAP_TICKS            = 4
) (
    input  logic              clk_gen,
    input  logic              rst_n,
    input  logic              exit_valid_i,
    input  logic [EXIT_W-1:0] exit_value_i,
    output logic              clk_led_o,
    output logic              rst_led_o,
    output logic              pass_led_o,
    output logic              fail_led_o,
    output logic              done_o,
    output logic [EXIT_W-1:0] exit_code_o,
    output logic              exit_value_o
);

`ifdef STATUS_LED_BLINK_CODE_EN
    typedef enum logic [2:0] {
        S_RUN, S_PASS, S_FAIL_ON, S_FAIL_OFF, S_FAIL_GAP
    } state_t;

    localparam logic [3:0] GAP_INIT = 4'(GAP_TICKS);

    // Pulses per burst: the low nibble, with 0 meaning 16.
    function automatic logic [4:0] burst_len(input logic [3:0] nib);
        return (nib == 4'd0) ? 5'd16 : {1'b0, nib};
    endfunction

    logic [4:0] n_q, n_d;
    logic [3:0] gap_q, gap_d;
`else
    typedef enum logic [1:0] {
        S_RUN, S_PASS, S_FAIL
    } state_t;
`endif

    state_t                          state_q, state_d;
    logic [CLK_LED_COUNT_LENGTH-1:0] hb_q;
    logic [BLINK_PRESCALE_W-1:0]     pre_q;
    logic                            sync1_q, sync2_q;
    logic                            rst_led_q;
    logic                            done_q, done_d;
    logic [EXIT_W-1:0]               code_q, code_d;
    logic                            pass_led_q, pass_led_d;
    logic                            fail_led_q, fail_led_d;
    logic                            tick;
    logic                            capture;

    assign tick    = (pre_q == '1);
    assign capture = (state_q == S_RUN) && sync2_q;

    // Free-running counters, exit strobe synchroniser and all registered state.
    always_ff @(posedge clk_gen or negedge rst_n) begin
        if (!rst_n) begin
            hb_q       <= '0;
            pre_q      <= '0;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            rst_led_q  <= 1'b0;
            done_q     <= 1'b0;
            code_q     <= '0;
            pass_led_q <= 1'b0;
            fail_led_q <= 1'b0;
            state_q    <= S_RUN;
`ifdef STATUS_LED_BLINK_CODE_EN
            n_q        <= '0;
            gap_q      <= '0;
`endif
        end else begin
            hb_q       <= hb_q + 1'b1;
            pre_q      <= pre_q + 1'b1;
            sync1_q    <= exit_valid_i;
            sync2_q    <= sync1_q;
            rst_led_q  <= 1'b1;
            done_q     <= done_d;
            code_q     <= code_d;
            pass_led_q <= pass_led_d;
            fail_led_q <= fail_led_d;
            state_q    <= state_d;
`ifdef STATUS_LED_BLINK_CODE_EN
            n_q        <= n_d;
            gap_q      <= gap_d;
`endif
        end
    end

    // Next-state logic: capture from RUN, then pass/fail indication.
    always_comb begin
        state_d    = state_q;
        done_d     = done_q;
        code_d     = code_q;
        fail_led_d = fail_led_q;
`ifdef STATUS_LED_BLINK_CODE_EN
        n_d        = n_q;
        gap_d      = gap_q;
`endif
        case (state_q)
            S_RUN: begin
                if (capture) begin
                    done_d = 1'b1;
                    code_d = exit_value_i;
                    if (exit_value_i == '0) begin
                        state_d = S_PASS;
                    end else begin
`ifdef STATUS_LED_BLINK_CODE_EN
                        state_d = S_FAIL_ON;
                        n_d     = burst_len(exit_value_i[3:0]);
`else
                        state_d    = S_FAIL;
                        fail_led_d = 1'b1;
`endif
                    end
                end
            end
            S_PASS: state_d = S_PASS;
`ifdef STATUS_LED_BLINK_CODE_EN
            S_FAIL_ON: begin
                if (tick) state_d = S_FAIL_OFF;
            end
            S_FAIL_OFF: begin
                if (tick) begin
                    if (n_q == 5'd1) begin
                        state_d = S_FAIL_GAP;
                        gap_d   = GAP_INIT;
                    end else begin
                        state_d = S_FAIL_ON;
                        n_d     = n_q - 5'd1;
                    end
                end
            end
            S_FAIL_GAP: begin
                if (tick) begin
                    if (gap_q == 4'd1) begin
                        state_d = S_FAIL_ON;
                        n_d     = burst_len(code_q[3:0]);
                    end else begin
                        gap_d = gap_q - 4'd1;
                    end
                end
            end
`else
            S_FAIL: begin
                if (tick) fail_led_d = ~fail_led_q;
            end
`endif
            default: state_d = S_RUN;
        endcase
        pass_led_d = (state_d == S_PASS);
`ifdef STATUS_LED_BLINK_CODE_EN
        fail_led_d = (state_d == S_FAIL_ON);
`endif
    end

    assign clk_led_o    = hb_q[CLK_LED_COUNT_LENGTH-1];
    assign rst_led_o    = rst_led_q;
    assign pass_led_o   = pass_led_q;
    assign fail_led_o   = fail_led_q;
    assign done_o       = done_q;
    assign exit_code_o  = code_q;
    assign exit_value_o = code_q[0];

endmodule

// File: tb/tb_fpga_status_led_ctrl.sv
// tb_fpga_status_led_ctrl: directed + randomized bench for fpga_status_led_ctrl.
// Expected outputs come from an arithmetic model of edge counts since reset
// release (prescale 4, heartbeat period 16). Honors STATUS_LED_BLINK_CODE_EN.
module tb_fpga_status_led_ctrl;

    logic        clk_gen = 1'b0;
    logic        rst_n = 1'b0;
    logic        exit_valid_i = 1'b0;
    logic [31:0] exit_value_i = '0;
    logic        clk_led_o, rst_led_o, pass_led_o, fail_led_o, done_o, exit_value_o;
    logic [31:0] exit_code_o;

    int tests = 0;
    int fails = 0;
    int e = 0;            // rising edges since reset release
    int cap_e = -1;       // edge at which capture is expected (-1: none)
    logic [31:0] cap_v = '0;

    fpga_status_led_ctrl #(
        .CLK_LED_COUNT_LENGTH(4),
        .BLINK_PRESCALE_W(2),
        .EXIT_W(32),
        .GAP_TICKS(4)
    ) dut (
        .clk_gen(clk_gen),
        .rst_n(rst_n),
        .exit_valid_i(exit_valid_i),
        .exit_value_i(exit_value_i),
        .clk_led_o(clk_led_o),
        .rst_led_o(rst_led_o),
        .pass_led_o(pass_led_o),
        .fail_led_o(fail_led_o),
        .done_o(done_o),
        .exit_code_o(exit_code_o),
        .exit_value_o(exit_value_o)
    );

    always #5 clk_gen = ~clk_gen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s at edge %0d: observed=%0h expected=%0h", tag, e, obs, expv);
        end
    endtask

    // Fail LED level after edge k. Ticks act on edges that are multiples of 4.
    function automatic logic exp_fail(input int k);
        int t1, j;
        logic [3:0] nib;
        int n, m;
        if (cap_e < 0 || k < cap_e || cap_v == 32'd0) return 1'b0;
        t1 = ((cap_e / 4) + 1) * 4;
        if (k < t1) return 1'b1;
        j = (k - t1) / 4;
`ifdef STATUS_LED_BLINK_CODE_EN
        nib = cap_v[3:0];
        n = (nib == 4'd0) ? 16 : int'(nib);
        m = (j + 1) % (2 * n + 4);
        return (m < 2 * n) && (m % 2 == 0);
`else
        nib = 4'd0;
        n = 0;
        m = nib + n;
        return (j % 2) == 1;
`endif
    endfunction

    task automatic check_all();
        logic        d;
        logic [31:0] code;
        d = (cap_e >= 0) && (e >= cap_e);
        code = d ? cap_v : 32'd0;
        chk("rst_led", {31'd0, rst_led_o}, {31'd0, e >= 1});
        chk("clk_led", {31'd0, clk_led_o}, {31'd0, (e % 16) >= 8});
        chk("done", {31'd0, done_o}, {31'd0, d});
        chk("exit_code", exit_code_o, code);
        chk("exit_value", {31'd0, exit_value_o}, {31'd0, code[0]});
        chk("pass_led", {31'd0, pass_led_o}, {31'd0, d && (cap_v == 32'd0)});
        chk("fail_led", {31'd0, fail_led_o}, {31'd0, exp_fail(e)});
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_outs"}, {26'd0, clk_led_o, rst_led_o, pass_led_o, fail_led_o,
                             done_o, exit_value_o}, 32'd0);
        chk({tag, "_code"}, exit_code_o, 32'd0);
    endtask

    task automatic step_check(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk_gen);
            #1;
            e++;
            check_all();
        end
    endtask

    // Called at #1 after a rising edge; releases reset between edges.
    task automatic do_reset();
        rst_n = 1'b0;
        exit_valid_i = 1'b0;
        #1;
        check_zero("reset_async");
        @(posedge clk_gen);
        #1;
        check_zero("reset_hold");
        rst_n = 1'b1;
        e = 0;
        cap_e = -1;
        cap_v = '0;
    endtask

    task automatic run_scn(input logic [31:0] v, input int pre, input int len);
        step_check(pre);
        exit_value_i = v;
        exit_valid_i = 1'b1;
        cap_e = e + 3;
        cap_v = v;
        step_check(len);
    endtask

    task automatic sticky(input logic [31:0] v2);
        exit_valid_i = 1'b0;
        step_check(3);
        exit_value_i = v2;
        exit_valid_i = 1'b1;
        step_check(12);
        exit_valid_i = 1'b0;
    endtask

    initial begin
        logic [31:0] v;
        int found;
        #2;
        check_zero("por");
        @(posedge clk_gen);
        #1;
        do_reset();

        // Heartbeat and out-of-reset indicator
        step_check(40);

        // Pass, then late strobes are ignored
        run_scn(32'd0, int'($urandom_range(0, 7)), 30);
        sticky(32'h5);

        // Fail code
        do_reset();
`ifdef STATUS_LED_BLINK_CODE_EN
        run_scn(32'h3, int'($urandom_range(0, 7)), 130);
`else
        run_scn(32'h5, int'($urandom_range(0, 7)), 100);
`endif

        // Low nibble zero -> 16 pulses; sticky capture
        do_reset();
        run_scn(32'h20, int'($urandom_range(0, 7)), 200);
        sticky(32'h0);

        // Reset in the middle of a fail pulse
        do_reset();
        run_scn(32'h3, 2, 8);
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            if (exp_fail(e) && exp_fail(e + 1)) found = 1;
            else step_check(1);
        end
        chk("midburst_found", found, 1);
        do_reset();
        run_scn(32'd0, 3, 20);

        // Randomized captures
        for (int r = 0; r < 6; r++) begin
            do_reset();
            case ($urandom_range(0, 3))
                0: v = 32'd0;
                1: v = {28'd0, 4'($urandom_range(1, 15))};
                2: v = {$urandom, 4'd0};
                default: v = $urandom;
            endcase
            run_scn(v, int'($urandom_range(0, 9)), 120);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
